// File: rtl/xor_stream_cipher_if.sv
// Streaming XOR cipher bus: key/message input beats and cipher output status.
interface xor_stream_cipher_if #(
    parameter int unsigned DATA_W = 1
);
    logic              ena;
    logic [DATA_W-1:0] iData_in;
    logic              iKey_flag;
    logic              iMsg_flag;
    logic [1:0]        iMode;
    logic [DATA_W-1:0] oData_out;
    logic              oData_valid;
    logic              oKey_loaded;
    logic              oBusy;
    logic              oDone;
    logic              oError;

    // Source of key/message beats; observes cipher results.
    modport master (
        output ena, iData_in, iKey_flag, iMsg_flag, iMode,
        input  oData_out, oData_valid, oKey_loaded, oBusy, oDone, oError
    );

    // The cipher itself.
    modport slave (
        input  ena, iData_in, iKey_flag, iMsg_flag, iMode,
        output oData_out, oData_valid, oKey_loaded, oBusy, oDone, oError
    );
endinterface

// File: rtl/xor_stream_cipher.sv
// Streaming XOR cipher: serial key load, then per-beat XOR of message beats
// against a rotating key chunk (repeat, autokey-encrypt or autokey-decrypt).
module xor_stream_cipher #(
    parameter int unsigned MSG_SIZE = 64,
    parameter int unsigned KEY_SIZE = 16,
    parameter int unsigned DATA_W   = 1
) (
    input  logic               clk,
    input  logic               rst,
    xor_stream_cipher_if.slave bus
);

    localparam int unsigned KB     = KEY_SIZE / DATA_W;
    localparam int unsigned MB     = MSG_SIZE / DATA_W;
    localparam int unsigned KCNT_W = $clog2(KB) + 1;
    localparam int unsigned MCNT_W = $clog2(MB) + 1;
    localparam int unsigned IDX_W  = (KB > 1) ? $clog2(KB) : 1;

    localparam logic [1:0] MODE_REPEAT   = 2'b00;
    localparam logic [1:0] MODE_AUTO_ENC = 2'b01;
    localparam logic [1:0] MODE_AUTO_DEC = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_KEY,
        S_KEY_READY,
        S_STREAM,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [KEY_SIZE-1:0] key_q;
    logic [KEY_SIZE-1:0] wkey_q;
    logic [KCNT_W-1:0]   kcnt_q;
    logic [MCNT_W-1:0]   mcnt_q;
    logic [IDX_W-1:0]    kidx_q;
    logic [1:0]          mode_q;
    logic [DATA_W-1:0]   data_q;
    logic                valid_q;
    logic                key_loaded_q;
    logic                busy_q;
    logic                done_q;
    logic                error_q;

    logic                frame_start;
    logic                both_flags;
    logic [KEY_SIZE-1:0] src_key;
    logic [IDX_W-1:0]    idx;
    logic [31:0]         sh;
    logic [DATA_W-1:0]   chunk;
    logic [DATA_W-1:0]   new_chunk;
    logic [DATA_W-1:0]   beat_d;
    logic [KEY_SIZE-1:0] mask;
    logic [KEY_SIZE-1:0] wkey_d;
    logic [KEY_SIZE-1:0] key_d;
    logic [IDX_W-1:0]    kidx_d;
    logic [MCNT_W-1:0]   mcnt_d;
    logic [KCNT_W-1:0]   kcnt_d;
    logic [1:0]          mode_d;
    logic                last_beat;
    logic                key_full;

    // Datapath for the beat presented this cycle; the FSM decides whether to commit it.
    always_comb begin
        both_flags  = bus.iKey_flag & bus.iMsg_flag;
        frame_start = (state_q == S_KEY_READY);

        // A new frame works from a fresh copy of the held key, starting at chunk 0.
        src_key = frame_start ? key_q : wkey_q;
        idx     = frame_start ? IDX_W'(0) : kidx_q;
        mode_d  = mode_q;
        if (frame_start) begin
            mode_d = (bus.iMode == 2'b11) ? MODE_REPEAT : bus.iMode;
        end

        // Chunk 0 sits at the MSB end of the key.
        sh     = KEY_SIZE - DATA_W - (DATA_W * 32'(idx));
        chunk  = DATA_W'(src_key >> sh);
        beat_d = bus.iData_in ^ chunk;

        new_chunk = chunk;
        case (mode_d)
            MODE_AUTO_ENC: new_chunk = beat_d;
            MODE_AUTO_DEC: new_chunk = bus.iData_in;
            default:       new_chunk = chunk;
        endcase

        mask   = KEY_SIZE'({DATA_W{1'b1}}) << sh;
        wkey_d = (src_key & ~mask) | (KEY_SIZE'(new_chunk) << sh);

        kidx_d = (idx == IDX_W'(KB - 1)) ? IDX_W'(0) : idx + IDX_W'(1);

        mcnt_d    = frame_start ? MCNT_W'(1) : mcnt_q + MCNT_W'(1);
        last_beat = (mcnt_d == MCNT_W'(MB));

        // Key beats enter at the LSB end so the first beat ends up at the MSB.
        key_d    = (key_q << DATA_W) | KEY_SIZE'(bus.iData_in);
        kcnt_d   = (state_q == S_LOAD_KEY) ? kcnt_q + KCNT_W'(1) : KCNT_W'(1);
        key_full = (kcnt_d == KCNT_W'(KB));
    end

    // Control FSM with registered outputs; ena low freezes everything but the pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            key_q        <= '0;
            wkey_q       <= '0;
            kcnt_q       <= '0;
            mcnt_q       <= '0;
            kidx_q       <= '0;
            mode_q       <= MODE_REPEAT;
            data_q       <= '0;
            valid_q      <= 1'b0;
            key_loaded_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else if (!bus.ena) begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            if (both_flags) begin
                // Ambiguous beat: reject it and leave the state alone.
                error_q <= 1'b1;
            end else if (bus.iKey_flag &&
                         (state_q inside {S_IDLE, S_LOAD_KEY, S_KEY_READY})) begin
                key_q <= key_d;
                if (key_full) begin
                    state_q      <= S_KEY_READY;
                    kcnt_q       <= '0;
                    key_loaded_q <= 1'b1;
                    error_q      <= 1'b0;
                end else begin
                    state_q      <= S_LOAD_KEY;
                    kcnt_q       <= kcnt_d;
                    key_loaded_q <= 1'b0;
                end
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.iMsg_flag) begin
                            error_q <= 1'b1;
                        end
                    end
                    S_LOAD_KEY: begin
                        // Key flag dropped early: the partial key is useless.
                        state_q      <= S_IDLE;
                        kcnt_q       <= '0;
                        key_loaded_q <= 1'b0;
                        if (bus.iMsg_flag) begin
                            error_q <= 1'b1;
                        end
                    end
                    S_KEY_READY, S_STREAM: begin
                        if (bus.iMsg_flag) begin
                            data_q  <= beat_d;
                            valid_q <= 1'b1;
                            wkey_q  <= wkey_d;
                            kidx_q  <= kidx_d;
                            mcnt_q  <= mcnt_d;
                            mode_q  <= mode_d;
                            if (last_beat) begin
                                state_q <= S_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= S_STREAM;
                                busy_q  <= 1'b1;
                            end
                        end else if (bus.iKey_flag) begin
                            error_q <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        // Needs one flag-low cycle before the next frame can start.
                        if (bus.iMsg_flag) begin
                            error_q <= 1'b1;
                        end else begin
                            state_q <= S_KEY_READY;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.oData_out   = data_q;
    assign bus.oData_valid = valid_q;
    assign bus.oKey_loaded = key_loaded_q;
    assign bus.oBusy       = busy_q;
    assign bus.oDone       = done_q;
    assign bus.oError      = error_q;

endmodule

// File: tb/tb_xor_stream_cipher.sv
// Scoreboard bench for xor_stream_cipher with 1-bit and 8-bit beat instances.
module tb_xor_stream_cipher;

    typedef struct {
        logic [7:0] d;
        logic       last;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t q1[$];
    exp_t q8[$];
    exp_t e1;
    exp_t e8;

    localparam logic [15:0] KEY   = 16'hA5C3;
    localparam logic [63:0] PLAIN = 64'h0123456789ABCDEF;
    localparam logic [63:0] C_REP = 64'hA4E0E0A42C68682C;
    localparam logic [63:0] C_AUT = 64'hA4E0E187682CA5C3;

    xor_stream_cipher_if #(.DATA_W(1)) if1 ();
    xor_stream_cipher_if #(.DATA_W(8)) if8 ();

    xor_stream_cipher #(.MSG_SIZE(64), .KEY_SIZE(16), .DATA_W(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    xor_stream_cipher #(.MSG_SIZE(64), .KEY_SIZE(16), .DATA_W(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (if8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor for the 1-bit instance.
    always @(negedge clk) begin
        if (if1.oData_valid === 1'b1) begin
            chk("dut1 beat expected", 64'(q1.size() != 0), 64'(1));
            if (q1.size() != 0) begin
                e1 = q1.pop_front();
                chk("dut1 data", 64'(if1.oData_out), 64'(e1.d[0]));
                chk("dut1 done", 64'(if1.oDone), 64'(e1.last));
                chk("dut1 latency", 64'(cyc), 64'(e1.cyc));
            end
        end else begin
            chk("dut1 done without valid", 64'(if1.oDone), 64'(0));
        end
    end

    // Monitor for the 8-bit instance.
    always @(negedge clk) begin
        if (if8.oData_valid === 1'b1) begin
            chk("dut8 beat expected", 64'(q8.size() != 0), 64'(1));
            if (q8.size() != 0) begin
                e8 = q8.pop_front();
                chk("dut8 data", 64'(if8.oData_out), 64'(e8.d));
                chk("dut8 done", 64'(if8.oDone), 64'(e8.last));
                chk("dut8 latency", 64'(cyc), 64'(e8.cyc));
            end
        end else begin
            chk("dut8 done without valid", 64'(if8.oDone), 64'(0));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic key1(input logic [15:0] k, input int nb);
        for (int i = 0; i < nb; i++) begin
            tick();
            if1.iKey_flag = 1'b1;
            if1.iData_in  = k[15-i];
        end
        tick();
        if1.iKey_flag = 1'b0;
    endtask

    task automatic frame1(input logic [63:0] msg, input logic [63:0] expv,
                          input logic [1:0] mode, input int nb);
        if1.iMode = mode;
        for (int i = 0; i < nb; i++) begin
            tick();
            if1.iMsg_flag = 1'b1;
            if1.iData_in  = msg[63-i];
            q1.push_back('{8'(expv[63-i]), (i == 63), cyc + 1});
        end
        tick();
        if1.iMsg_flag = 1'b0;
    endtask

    // gkind: 0 = flag-low pause, 1 = stray key beat, 2 = ena low with a message beat
    task automatic frame8(input logic [63:0] msg, input logic [63:0] expv,
                          input logic [1:0] mode, input logic [7:0] gmask, input int gkind);
        if8.iMode = mode;
        for (int i = 0; i < 8; i++) begin
            if (gmask[i]) begin
                tick();
                if8.iMsg_flag = 1'b0;
                if (gkind == 1) begin
                    if8.iKey_flag = 1'b1;
                end else if (gkind == 2) begin
                    if8.ena       = 1'b0;
                    if8.iMsg_flag = 1'b1;
                    if8.iData_in  = 8'hFF;
                end
            end
            tick();
            if8.ena       = 1'b1;
            if8.iKey_flag = 1'b0;
            if8.iMsg_flag = 1'b1;
            if8.iData_in  = msg[63-8*i -: 8];
            q8.push_back('{expv[63-8*i -: 8], (i == 7), cyc + 1});
        end
        tick();
        if8.iMsg_flag = 1'b0;
    endtask

    task automatic status1(input string tag, input logic kl, input logic bsy, input logic err);
        @(negedge clk);
        chk({tag, " dut1 key_loaded"}, 64'(if1.oKey_loaded), 64'(kl));
        chk({tag, " dut1 busy"}, 64'(if1.oBusy), 64'(bsy));
        chk({tag, " dut1 error"}, 64'(if1.oError), 64'(err));
    endtask

    task automatic status8(input string tag, input logic kl, input logic bsy, input logic err);
        @(negedge clk);
        chk({tag, " dut8 key_loaded"}, 64'(if8.oKey_loaded), 64'(kl));
        chk({tag, " dut8 busy"}, 64'(if8.oBusy), 64'(bsy));
        chk({tag, " dut8 error"}, 64'(if8.oError), 64'(err));
    endtask

    task automatic all_zero1(input string tag);
        chk({tag, " valid"}, 64'(if1.oData_valid), 64'(0));
        chk({tag, " data"}, 64'(if1.oData_out), 64'(0));
        chk({tag, " key_loaded"}, 64'(if1.oKey_loaded), 64'(0));
        chk({tag, " busy"}, 64'(if1.oBusy), 64'(0));
        chk({tag, " done"}, 64'(if1.oDone), 64'(0));
        chk({tag, " error"}, 64'(if1.oError), 64'(0));
    endtask

    initial begin
        rst = 1'b1;
        if1.ena = 1'b1; if1.iData_in = '0; if1.iKey_flag = 1'b0; if1.iMsg_flag = 1'b0; if1.iMode = 2'b00;
        if8.ena = 1'b1; if8.iData_in = '0; if8.iKey_flag = 1'b0; if8.iMsg_flag = 1'b0; if8.iMode = 2'b00;
        #12;
        all_zero1("reset");
        chk("reset dut8 data", 64'(if8.oData_out), 64'(0));
        chk("reset dut8 key_loaded", 64'(if8.oKey_loaded), 64'(0));
        #10;
        rst = 1'b0;

        // 1-bit beats: key load and the three cipher modes
        key1(KEY, 16);
        status1("key loaded", 1'b1, 1'b0, 1'b0);
        frame1(PLAIN, C_REP, 2'b00, 64);
        status1("repeat frame", 1'b1, 1'b0, 1'b0);
        frame1(PLAIN, C_AUT, 2'b01, 64);
        frame1(PLAIN, C_AUT, 2'b01, 64);
        status1("autokey frames", 1'b1, 1'b0, 1'b0);
        frame1(C_AUT, PLAIN, 2'b10, 64);
        frame1(PLAIN, C_REP, 2'b11, 64);
        status1("mode 11 frame", 1'b1, 1'b0, 1'b0);

        // both flags high in KEY_READY
        tick();
        if1.iKey_flag = 1'b1;
        if1.iMsg_flag = 1'b1;
        tick();
        if1.iKey_flag = 1'b0;
        if1.iMsg_flag = 1'b0;
        status1("both flags", 1'b1, 1'b0, 1'b1);

        // full reload clears the sticky error
        key1(KEY, 16);
        status1("reload", 1'b1, 1'b0, 1'b0);

        // partial key, then a message beat in IDLE
        key1(KEY, 9);
        status1("partial key", 1'b0, 1'b0, 1'b0);
        tick();
        if1.iMsg_flag = 1'b1;
        tick();
        if1.iMsg_flag = 1'b0;
        @(negedge clk);
        chk("msg in idle valid", 64'(if1.oData_valid), 64'(0));
        chk("msg in idle error", 64'(if1.oError), 64'(1));
        chk("msg in idle key_loaded", 64'(if1.oKey_loaded), 64'(0));

        // reset in the middle of a frame
        key1(KEY, 16);
        frame1(PLAIN, C_REP, 2'b00, 30);
        @(negedge clk);
        #1;
        chk("mid-frame busy", 64'(if1.oBusy), 64'(1));
        rst = 1'b1;
        #1;
        all_zero1("mid-frame reset");
        chk("mid-frame queue drained", 64'(q1.size()), 64'(0));
        #2;
        rst = 1'b0;
        key1(KEY, 16);
        frame1(PLAIN, C_REP, 2'b00, 64);
        status1("after reset frame", 1'b1, 1'b0, 1'b0);

        // 8-bit beats
        tick();
        if8.iKey_flag = 1'b1;
        if8.iData_in  = 8'hA5;
        tick();
        if8.iData_in  = 8'hC3;
        tick();
        if8.iKey_flag = 1'b0;
        status8("key loaded", 1'b1, 1'b0, 1'b0);
        frame8(PLAIN, C_REP, 2'b00, 8'h00, 0);
        frame8(PLAIN, C_REP, 2'b00, 8'b0101_0110, 0);
        status8("gapped repeat", 1'b1, 1'b0, 1'b0);
        frame8(PLAIN, C_AUT, 2'b01, 8'b1000_0010, 2);
        status8("ena gaps", 1'b1, 1'b0, 1'b0);
        frame8(C_AUT, PLAIN, 2'b10, 8'b0010_1000, 1);
        status8("key in stream", 1'b1, 1'b0, 1'b1);

        repeat (4) tick();
        chk("dut1 queue empty", 64'(q1.size()), 64'(0));
        chk("dut8 queue empty", 64'(q8.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/xor_stream_cipher.md
Name: xor_stream_cipher

Overview:
- Parametrised streaming successor to the fixed 64-bit-message / 16-bit-key serial XOR encryptor.
- Accepts a key and then message beats DATA_W bits wide on a shared input bus, and XORs each message beat with the current key chunk.
- Emits ciphertext beat-by-beat with 1-cycle latency; no whole-message buffering.
- Adds selectable repeating-key, autokey-encrypt and autokey-decrypt modes, frame completion and protocol-error reporting.
- Sits between the pad-level inputs and the output pins of the top-level design.

Parameters:
- MSG_SIZE, 64, message bits per frame; must be a multiple of DATA_W.
- KEY_SIZE, 16, key bits; must be a multiple of DATA_W and ≤ MSG_SIZE.
- DATA_W, 1, bits transferred per beat on iData_in / oData_out.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ena  in  1  global enable; when low, all state holds and no beats are accepted.
- iData_in  in  DATA_W  shared key/message data, MSB-first by beat.
- iKey_flag  in  1  current beat is key data.
- iMsg_flag  in  1  current beat is message data.
- iMode  in  2  cipher mode: 00 repeat, 01 autokey-encrypt, 10 autokey-decrypt, 11 treated as 00.
- oData_out  out  DATA_W  ciphertext/plaintext beat.
- oData_valid  out  1  oData_out holds a valid beat this cycle.
- oKey_loaded  out  1  a full key is held.
- oBusy  out  1  a frame is in progress.
- oDone  out  1  single-cycle pulse after the last beat of a frame is output.
- oError  out  1  sticky protocol-violation flag; cleared only by rst or a new complete key load.

Behaviour:
- Reset (async, rst=1): all outputs 0, all counters 0, state IDLE, key and working-key registers 0.
- Beat counts: KB = KEY_SIZE/DATA_W key beats; MB = MSG_SIZE/DATA_W message beats. Counter widths are $clog2(KB)+1 and $clog2(MB)+1.
- States:
  - IDLE: wait for a key.
  - LOAD_KEY: key beats being shifted in.
  - KEY_READY: key held, no frame active.
  - STREAM: message beats being processed.
  - DONE: frame complete.
- A beat is accepted only when ena=1 and exactly one flag is high. If both flags are high: nothing is accepted, oError is set, and state is unchanged.
- Key load:
  - IDLE or KEY_READY + iKey_flag → LOAD_KEY. The beat is shifted into the key register from the LSB end, so the first beat ends at the MSB.
  - After KB accepted beats: oKey_loaded=1, oError cleared, state → KEY_READY.
  - If iKey_flag drops before KB beats: partial key discarded, oKey_loaded=0, state → IDLE.
- Frame start: iMsg_flag in KEY_READY loads working_key ← key, sets chunk index k=0, sets oBusy=1, and processes that same beat.
- iMsg_flag in IDLE or LOAD_KEY: beat is dropped and oError is set.
- STREAM processing:
  - Per accepted beat: out = iData_in ^ working_key chunk k, where chunk 0 = the MSB DATA_W bits.
  - Next cycle: oData_out=out and oData_valid=1. Otherwise oData_valid=0 and oData_out holds its value.
  - Chunk update: mode 01 writes out into chunk k; mode 10 writes iData_in into chunk k; mode 00 leaves the chunk unchanged.
  - k wraps from KB-1 to 0.
  - iMsg_flag low in STREAM is a pause: no output, all state held.
  - iMode is sampled at frame start and held for the frame.
- Frame end: after the MB-th beat is accepted, state → DONE. oDone pulses in the same cycle the final oData_valid is high; oBusy falls in that cycle.
- DONE:
  - Further iMsg_flag beats while in DONE are dropped and set oError.
  - Returns to KEY_READY once iMsg_flag=0, so back-to-back frames need at least one flag-low cycle.
  - The original key is reused for the next frame because the working key is reloaded.
- iKey_flag during STREAM: beat ignored, oError set.
- ena=0: oData_valid and oDone forced 0 for that cycle; all other state frozen.

Test Plan:
- Repeat mode, DATA_W=1: key 0xA5C3, msg 0x0123456789ABCDEF → oData_out sequence 0xA4E0E0A42C68682C MSB-first; 64 valid beats, each 1 cycle after acceptance; oDone with the last beat.
- Mode 01 with the same key/msg → 0xA4E0E187682CA5C3. Mode 10 fed 0xA4E0E187682CA5C3 → 0x0123456789ABCDEF.
- DATA_W=8, KEY_SIZE=16, MSG_SIZE=64, repeat mode, same vectors → bytes A4,E0,E0,A4,2C,68,68,2C on consecutive cycles; with gaps in iMsg_flag the output matches, with valid-gaps aligned to the input gaps.
- iKey_flag dropped after 9 of 16 beats → oKey_loaded=0, state IDLE; a following iMsg_flag sets oError=1 and oData_valid stays 0.
- Both flags high in KEY_READY → oError=1, no output. rst asserted mid-frame (beat 30) → all outputs 0 immediately. A full reload then produces a correct second frame.
- Two consecutive frames with 1 flag-low cycle between, mode 01 → both frames output 0xA4E0E187682CA5C3; oDone pulses twice.
